core_ctrl: RTL and testbench
============================

// Module: core_ctrl
// PURPOSE
//   Instruction sequencer that drives one core. It accepts a start pulse and a
//   valid/ready stream of Q then K vectors, and emits the 20-bit inst word plus
//   mem_in for one full tile: qmem/kmem fill, kernel load, execute, drain,
//   SFP accumulate, then normalise-and-write to pmem. Sits between the host or
//   testbench and the core instance.
// PARAMETERS
//   bw        8    bits per element
//   pr        8    elements per Q/K vector (mem_in width = pr*bw)
//   len       8    vectors per tile, 1..16 (qkmem_add and pmem_add are 4 bits)
//   drain_cyc 16   idle cycles between the last execute and the first ofifo read
// PORTS
//   clk       in   1       clock, rising edge
//   reset     in   1       asynchronous, active-high
//   start     in   1       begin a tile; sampled only in IDLE
//   in_valid  in   1       in_data holds a vector
//   in_data   in   pr*bw   Q vectors (len), then K vectors (len)
//   in_ready  out  1       1 iff state is QLOAD or KLOAD (decoded from state reg)
//   mem_in    out  pr*bw   data to core qmem/kmem
//   inst      out  20      core instruction word, registered
//   busy      out  1       1 in every state except IDLE
//   done      out  1       one-cycle pulse at tile completion
//   phase     out  3       current state encoding, for debug
// BEHAVIOUR
// - inst field map:
//   [19] sfp_pmem_wr, [18] acc, [17] div, [16] ofifo_rd, [15:12] qkmem_add,
//   [11:8] pmem_add, [7] execute, [6] kernel load / kmem select,
//   [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
// - All outputs are registered. Any inst bit not listed for the current cycle is 0.
//   mem_in is 0 on every cycle that is not a write.
// - Reset (async): state=IDLE, cnt=0, inst=0, mem_in=0, busy=0, done=0. Takes
//   effect immediately, including mid-tile; no partial sequence resumes.
// - Counter: 5-bit cnt. It is cleared on every state entry. Addresses use cnt[3:0].
// - State sequence (phase encoding 0..7):
//   IDLE(0)
//     start=1 -> QLOAD. start is ignored in every other state.
//   QLOAD(1)
//     Each accepted beat (in_valid & in_ready) produces on the next edge:
//     inst[4]=1, qkmem_add=cnt, mem_in=in_data; then cnt++.
//     A cycle with no beat produces inst=0 (bubble).
//     After the len-th beat -> KLOAD.
//   KLOAD(2)
//     Same as QLOAD, but uses inst[2].
//     After the len-th beat -> KMAC. in_ready drops on that same edge.
//   KMAC(3)
//     len cycles of inst[3]=1, inst[6]=1, qkmem_add=cnt.
//     Then 1 extra cycle with inst[6]=1 only (covers the SRAM read latency).
//     -> EXEC.
//   EXEC(4)
//     len cycles of inst[5]=1, inst[7]=1, qkmem_add=cnt.
//     Then 1 extra cycle with inst[7]=1 only.
//     -> DRAIN.
//   DRAIN(5)
//     drain_cyc cycles with inst=0.
//     -> ACC.
//   ACC(6)
//     len cycles of inst[16]=1, inst[18]=1.
//     -> NORM.
//   NORM(7)
//     len cycles of inst[17]=1, inst[19]=1, inst[0]=1, pmem_add=cnt.
//     On the last NORM edge: done=1, then -> IDLE.
// - done is high for exactly one cycle, the cycle after the last NORM inst.
//   busy is 0 in that same cycle.
// - in_valid while in_ready=0 is ignored. The stream must hold data until accepted.
// - Throughput: with in_valid held at 1, start->done takes 6*len+drain_cyc+4
//   cycles (68 at defaults).
// - len=1 boundary: every phase still issues its extra latency cycle where one
//   is specified.
// TESTING
// 1 Reset: assert reset mid-EXEC
//     -> inst, mem_in, busy and done go to 0 asynchronously.
//     After release with no start, outputs stay idle for 20 cycles.
// 2 Streaming tile (defaults, in_valid always 1, Q=i*0x0101..., K=0xA0+i)
//     -> 8 qmem writes at addr 0..7, then 8 kmem writes with matching mem_in;
//     done 68 cycles after start.
// 3 Bubbles: in_valid toggles 1,0,1,0 during QLOAD
//     -> inst=0 on the bubble cycles; qkmem_add stays contiguous 0..7;
//     KLOAD starts only after 8 accepted beats.
// 4 Phase check: compare inst per cycle to the golden trace
//     -> KMAC shows 9 cycles with [6]=1 (8 with [3]); EXEC shows 9 with [7]
//     (8 with [5]); 16 zero cycles; 8 ACC; 8 NORM with pmem_add 0..7.
// 5 start held high for the whole tile
//     -> exactly one tile runs; a second tile begins the cycle after done
//     (IDLE then QLOAD).
// 6 len=1, drain_cyc=2
//     -> single write in each load phase; done 12 cycles after start.

Source files
------------

// File: rtl/core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_ctrl
// Brief    : Instruction sequencer for one core. Takes a start pulse and a
//            valid/ready stream of Q then K vectors, and issues the inst word
//            and mem_in for one tile: qmem/kmem fill, kernel load, execute,
//            drain, SFP accumulate, normalise-and-write to pmem.
// Revision : 1.0 - initial release
// ============================================================================
module core_ctrl #(
   parameter int BW        = 8,   // bits per element
   parameter int PR        = 8,   // elements per vector
   parameter int LEN       = 8,   // vectors per tile, 1..16
   parameter int DRAIN_CYC = 16   // idle cycles before the first ofifo read, >= 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               in_valid,
   input  logic [PR*BW-1:0]   in_data,
   output logic               in_ready,
   output logic [PR*BW-1:0]   mem_in,
   output logic [19:0]        inst,
   output logic               busy,
   output logic               done,
   output logic [2:0]         phase
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_QLOAD = 3'd1,
      S_KLOAD = 3'd2,
      S_KMAC  = 3'd3,
      S_EXEC  = 3'd4,
      S_DRAIN = 3'd5,
      S_ACC   = 3'd6,
      S_NORM  = 3'd7
   } state_t;

   // Counter compare points; cnt is 5 bits so the extra latency cycle at
   // LEN=16 and drain lengths up to 32 both fit.
   localparam logic [4:0] c_len_last   = 5'(LEN - 1);
   localparam logic [4:0] c_len        = 5'(LEN);
   localparam logic [4:0] c_drain_last = 5'(DRAIN_CYC - 1);

   // inst bit positions
   localparam int c_sfp_pmem_wr = 19;
   localparam int c_acc         = 18;
   localparam int c_div         = 17;
   localparam int c_ofifo_rd    = 16;
   localparam int c_execute     = 7;
   localparam int c_kernel_load = 6;
   localparam int c_qmem_rd     = 5;
   localparam int c_qmem_wr     = 4;
   localparam int c_kmem_rd     = 3;
   localparam int c_kmem_wr     = 2;
   localparam int c_pmem_wr     = 0;

   state_t              r_state;
   logic [4:0]          r_cnt;
   logic [19:0]         r_inst;
   logic [PR*BW-1:0]    r_mem_in;
   logic                r_busy;
   logic                r_done;

   state_t              w_state;
   logic [4:0]          w_cnt;
   logic [19:0]         w_inst;
   logic [PR*BW-1:0]    w_mem_in;
   logic                w_done;
   logic                w_beat;

   // The stream is only open while filling the two input memories
   assign in_ready = (r_state == S_QLOAD) || (r_state == S_KLOAD);
   assign w_beat   = in_valid & in_ready;

   assign inst   = r_inst;
   assign mem_in = r_mem_in;
   assign busy   = r_busy;
   assign done   = r_done;
   assign phase  = r_state;

   // Next-state and next-output decode; everything defaults to idle values
   always_comb begin
      w_state  = r_state;
      w_cnt    = r_cnt;
      w_inst   = '0;
      w_mem_in = '0;
      w_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state = S_QLOAD;
               w_cnt   = '0;
            end
         end
         S_QLOAD: begin
            if (w_beat) begin
               w_inst[c_qmem_wr] = 1'b1;
               w_inst[15:12]     = r_cnt[3:0];
               w_mem_in          = in_data;
               if (r_cnt == c_len_last) begin
                  w_state = S_KLOAD;
                  w_cnt   = '0;
               end else begin
                  w_cnt = r_cnt + 5'd1;
               end
            end
         end
         S_KLOAD: begin
            if (w_beat) begin
               w_inst[c_kmem_wr] = 1'b1;
               w_inst[15:12]     = r_cnt[3:0];
               w_mem_in          = in_data;
               if (r_cnt == c_len_last) begin
                  w_state = S_KMAC;
                  w_cnt   = '0;
               end else begin
                  w_cnt = r_cnt + 5'd1;
               end
            end
         end
         S_KMAC: begin
            // Kernel-load select stays up one extra cycle for the SRAM read latency
            w_inst[c_kernel_load] = 1'b1;
            if (r_cnt < c_len) begin
               w_inst[c_kmem_rd] = 1'b1;
               w_inst[15:12]     = r_cnt[3:0];
               w_cnt             = r_cnt + 5'd1;
            end else begin
               w_state = S_EXEC;
               w_cnt   = '0;
            end
         end
         S_EXEC: begin
            // Execute stays up one extra cycle for the last qmem read
            w_inst[c_execute] = 1'b1;
            if (r_cnt < c_len) begin
               w_inst[c_qmem_rd] = 1'b1;
               w_inst[15:12]     = r_cnt[3:0];
               w_cnt             = r_cnt + 5'd1;
            end else begin
               w_state = S_DRAIN;
               w_cnt   = '0;
            end
         end
         S_DRAIN: begin
            if (r_cnt == c_drain_last) begin
               w_state = S_ACC;
               w_cnt   = '0;
            end else begin
               w_cnt = r_cnt + 5'd1;
            end
         end
         S_ACC: begin
            w_inst[c_ofifo_rd] = 1'b1;
            w_inst[c_acc]      = 1'b1;
            if (r_cnt == c_len_last) begin
               w_state = S_NORM;
               w_cnt   = '0;
            end else begin
               w_cnt = r_cnt + 5'd1;
            end
         end
         S_NORM: begin
            // After the last pmem write, one closing edge raises done and idles
            if (r_cnt < c_len) begin
               w_inst[c_div]         = 1'b1;
               w_inst[c_sfp_pmem_wr] = 1'b1;
               w_inst[c_pmem_wr]     = 1'b1;
               w_inst[11:8]          = r_cnt[3:0];
               w_cnt                 = r_cnt + 5'd1;
            end else begin
               w_done  = 1'b1;
               w_state = S_IDLE;
               w_cnt   = '0;
            end
         end
         default: begin
            w_state = S_IDLE;
            w_cnt   = '0;
         end
      endcase
   end

   // State, counter and registered outputs; reset abandons any tile in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_inst   <= '0;
         r_mem_in <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_inst   <= w_inst;
         r_mem_in <= w_mem_in;
         r_busy   <= (w_state != S_IDLE);
         r_done   <= w_done;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_ctrl
// Brief    : Self-checking bench for core_ctrl with a trace-level reference
//            model and a second small-parameter instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_ctrl;

   localparam int LEN   = 8;
   localparam int DRAIN = 16;
   localparam int W     = 64;

   typedef struct packed {
      logic [19:0] inst;
      logic [2:0]  ph;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start, in_valid;
   logic [W-1:0]  in_data;
   logic          in_ready, busy, done;
   logic [W-1:0]  mem_in;
   logic [19:0]   inst;
   logic [2:0]    phase;

   logic          start1, valid1;
   logic [W-1:0]  data1;
   logic          ready1, busy1, done1;
   logic [W-1:0]  mem1;
   logic [19:0]   inst1;
   logic [2:0]    phase1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state
   int   m_stage;   // 0 idle, 1 loading, 2 playing the post-load trace
   int   m_qn, m_kn;
   ent_t post[$];

   int n3, n5, n6, n7, n16, n19;

   core_ctrl #(.BW(8), .PR(8), .LEN(LEN), .DRAIN_CYC(DRAIN)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .mem_in(mem_in), .inst(inst),
      .busy(busy), .done(done), .phase(phase)
   );

   core_ctrl #(.BW(8), .PR(8), .LEN(1), .DRAIN_CYC(2)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .in_valid(valid1),
      .in_data(data1), .in_ready(ready1), .mem_in(mem1), .inst(inst1),
      .busy(busy1), .done(done1), .phase(phase1)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void push(input logic [19:0] i, input logic [2:0] p);
      ent_t e;
      e.inst = i;
      e.ph   = p;
      post.push_back(e);
   endfunction

   // Everything a tile issues once the K stream is complete, written out
   // phase by phase as a flat list of inst words.
   function automatic void build_post();
      logic [19:0] w;
      post.delete();
      for (int i = 0; i < LEN; i++) begin
         w = 20'h00048; w[15:12] = 4'(i); push(w, 3'd3);
      end
      push(20'h00040, 3'd3);
      for (int i = 0; i < LEN; i++) begin
         w = 20'h000A0; w[15:12] = 4'(i); push(w, 3'd4);
      end
      push(20'h00080, 3'd4);
      for (int i = 0; i < DRAIN; i++) push(20'h0, 3'd5);
      for (int i = 0; i < LEN; i++) push(20'h50000, 3'd6);
      for (int i = 0; i < LEN; i++) begin
         w = 20'hA0001; w[11:8] = 4'(i); push(w, 3'd7);
      end
      push(20'h0, 3'd7);   // closing edge that raises done
   endfunction

   // One clock: predict from current inputs, take the edge, compare.
   task automatic cycle();
      logic [19:0]  ei;
      logic [W-1:0] em;
      logic         ed, eb;
      logic [2:0]   ep;
      ent_t         e;
      chk("in_ready", in_ready, (m_stage == 1));
      ei = '0; em = '0; ed = 1'b0;
      case (m_stage)
         0: if (start) begin m_stage = 1; m_qn = 0; m_kn = 0; end
         1: if (in_valid) begin
               em = in_data;
               if (m_qn < LEN) begin
                  ei = 20'h00010; ei[15:12] = 4'(m_qn); m_qn++;
               end else begin
                  ei = 20'h00004; ei[15:12] = 4'(m_kn); m_kn++;
                  if (m_kn == LEN) begin build_post(); m_stage = 2; end
               end
            end
         default: begin
            e  = post.pop_front();
            ei = e.inst;
            if (post.size() == 0) begin ed = 1'b1; m_stage = 0; end
         end
      endcase
      eb = (m_stage != 0);
      if (m_stage == 0)      ep = 3'd0;
      else if (m_stage == 1) ep = (m_qn < LEN) ? 3'd1 : 3'd2;
      else                   ep = post[0].ph;
      @(posedge clk);
      #1;
      cyc++;
      chk("inst", inst, ei);
      chk("mem_in", mem_in, em);
      chk("done", done, ed);
      chk("busy", busy, eb);
      chk("phase", phase, ep);
   endtask

   // mode 0: streaming Q=i*0x0101.., K=0xA0+i; 1: QLOAD valid toggles; 2: random
   task automatic run_tile(input int mode, input bit hold, input bit chk_lat);
      int s;
      bit got, tog;
      got = 0; tog = 1;
      n3 = 0; n5 = 0; n6 = 0; n7 = 0; n16 = 0; n19 = 0;
      start = 1'b1; in_valid = 1'b0;
      s = cyc;
      for (int k = 0; k < 400 && !got; k++) begin
         cycle();
         if (!hold) start = 1'b0;
         n3 += int'(inst[3]); n5 += int'(inst[5]); n6 += int'(inst[6]);
         n7 += int'(inst[7]); n16 += int'(inst[16]); n19 += int'(inst[19]);
         if (done) got = 1;
         if (m_stage == 1) begin
            if (m_qn < LEN) begin
               in_data = 64'h0101010101010101 * 64'(m_qn);
               if (mode == 1) begin in_valid = tog; tog = ~tog; end
               else in_valid = 1'b1;
            end else begin
               in_data  = 64'hA0 + 64'(m_kn);
               in_valid = 1'b1;
            end
            if (mode == 2) begin
               in_valid = ($urandom_range(0, 9) < 6);
               in_data  = {$urandom, $urandom};
            end
         end else begin
            in_valid = $urandom_range(0, 1);
            in_data  = {$urandom, $urandom};
         end
      end
      chk("done_seen", got, 1);
      if (chk_lat) chk("latency", cyc - s, 68);
   endtask

   initial begin
      int s, qw, kw, k6, k7;
      bit got;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      start1 = 1'b0; valid1 = 1'b0; data1 = '0;
      m_stage = 0; m_qn = 0; m_kn = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_inst", inst, 0);
      chk("rst_mem_in", mem_in, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_phase", phase, 0);
      reset = 1'b0;
      repeat (3) cycle();

      // streaming tile with golden-trace bit counts
      run_tile(0, 0, 1);
      chk("kmac_kl", n6, 9);
      chk("kmac_rd", n3, 8);
      chk("exec_ex", n7, 9);
      chk("exec_rd", n5, 8);
      chk("acc_cnt", n16, 8);
      chk("norm_cnt", n19, 8);
      repeat (2) cycle();

      // bubbles during QLOAD
      run_tile(1, 0, 0);
      cycle();

      // start held for the whole tile, then an immediate second tile
      run_tile(0, 1, 1);
      chk("hold_idle_phase", phase, 0);
      chk("hold_idle_busy", busy, 0);
      run_tile(0, 0, 1);
      cycle();

      // randomized tiles
      for (int t = 0; t < 3; t++) begin
         run_tile(2, 0, 0);
         repeat ($urandom_range(0, 3)) cycle();
      end

      // LEN=1, DRAIN_CYC=2 instance
      chk("l1_ready_idle", ready1, 0);
      start1 = 1'b1; valid1 = 1'b1; data1 = 64'h1122334455667788;
      s = cyc; got = 0; qw = 0; kw = 0; k6 = 0; k7 = 0;
      for (int k = 0; k < 50 && !got; k++) begin
         cycle();
         if (k == 0) chk("l1_phase_q", phase1, 1);
         start1 = 1'b0;
         if (inst1[4]) begin qw++; chk("l1_qdata", mem1, 64'h1122334455667788); end
         if (inst1[2]) begin kw++; chk("l1_kdata", mem1, 64'h1122334455667788); end
         k6 += int'(inst1[6]); k7 += int'(inst1[7]);
         if (done1) begin got = 1; chk("l1_busy_at_done", busy1, 0); end
      end
      chk("l1_done_seen", got, 1);
      chk("l1_latency", cyc - s, 12);
      chk("l1_qwrites", qw, 1);
      chk("l1_kwrites", kw, 1);
      chk("l1_kmac", k6, 2);
      chk("l1_exec", k7, 2);
      valid1 = 1'b0;

      // asynchronous reset in the middle of EXEC
      start = 1'b1; in_valid = 1'b1;
      cycle();
      start = 1'b0;
      for (int k = 0; k < 200 && !(m_stage == 2 && post[0].ph == 3'd4); k++) begin
         in_data = {$urandom, $urandom};
         cycle();
      end
      cycle(); cycle();
      chk("pre_rst_phase", phase, 4);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_inst", inst, 0);
      chk("arst_mem_in", mem_in, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_phase", phase, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_stage = 0; post.delete();
      for (int k = 0; k < 20; k++) begin
         in_valid = $urandom_range(0, 1);
         in_data  = {$urandom, $urandom};
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
